// File: rtl/ram_loader.sv
// ram_loader
// Streams a length-prefixed byte image into a small CPU RAM. The CPU is held
// in reset while the image loads and is released a few cycles after the last
// write. Upstream handshake is valid/ready. A bad length, or a bad checksum,
// parks the loader in a sticky error state until reset.
//
// Optional feature: define RAM_LOADER_CHECKSUM_EN to require one trailing
// checksum byte (mod-256 sum of the data bytes) after the image. Without the
// macro the last data byte goes straight to the reset-hold phase.
module ram_loader #(
  parameter int ADDR_W = 4,  // RAM address width; capacity 2**ADDR_W bytes
  parameter int HOLD   = 2   // cycles cpu_reset stays high after the last write (>= 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              error
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int          HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {
    WAIT_LEN,  // expecting the length byte
    LOAD,      // expecting data bytes
    CHECK,     // expecting the checksum byte (checksum build only)
    HOLD_RST,  // image complete, CPU still held in reset
    RUN,       // CPU running the loaded image
    ERROR      // image rejected; only reset leaves this state
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [ADDR_W-1:0]   index;     // address of the next data byte
  logic [ADDR_W-1:0]   last_idx;  // address of the final data byte (N-1)
  logic [7:0]          sum;       // running mod-256 sum of data bytes
  logic [HOLD_W-1:0]   hold_cnt;  // post-write reset-hold cycles elapsed

  logic                take;      // a byte transfers on this edge
  logic                len_ok;    // current in_data is a legal length
  logic                last_byte; // current transfer is the final data byte
  logic                hold_done; // final reset-hold cycle

  // A length of 0 or larger than the RAM is rejected.
  assign len_ok    = (in_data != 8'd0) && (32'(in_data) <= DEPTH);
  assign take      = in_valid && in_ready;
  assign last_byte = (index == last_idx);
  // The write cycle of the final data byte does not count towards the hold.
  assign hold_done = !ram_we && (hold_cnt == HOLD_W'(HOLD - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order blocks are evaluated.
    if (reset) begin
      state <= WAIT_LEN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    cpu_reset  = 1'b1;
    loaded     = 1'b0;
    error      = 1'b0;

    case (state)
      WAIT_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = len_ok ? LOAD : ERROR;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = HOLD_RST;
`endif
        end
      end

      // Unreachable unless the checksum build routes LOAD here.
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (in_data == sum) ? HOLD_RST : ERROR;
        end
      end

      HOLD_RST: begin
        if (hold_done) begin
          state_next = RUN;
        end
      end

      RUN: begin
        cpu_reset = 1'b0;
        loaded    = 1'b1;
        if (reload) begin
          state_next = WAIT_LEN;
        end
      end

      ERROR: begin
        error = 1'b1;
      end

      default: begin
        state_next = WAIT_LEN;
      end
    endcase
  end

  // Load datapath: image bookkeeping, the registered RAM write port and the
  // reset-hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= '0;
      last_idx <= '0;
      sum      <= 8'd0;
      hold_cnt <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= 8'd0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      ram_we <= 1'b0;

      // A legal length starts a fresh image at address 0.
      if (state == WAIT_LEN && take && len_ok) begin
        index    <= '0;
        sum      <= 8'd0;
        last_idx <= ADDR_W'(32'(in_data) - 32'd1);
      end

      // Each accepted data byte is written one cycle later.
      if (state == LOAD && take) begin
        ram_we   <= 1'b1;
        ram_addr <= index;
        ram_data <= in_data;
        index    <= index + 1'b1;
        sum      <= sum + in_data;
      end

      // Count hold cycles only once the final write has gone out.
      if (state == HOLD_RST && !ram_we) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
// Self-checking bench for ram_loader. Stimulus tasks push the writes an image
// must produce into a scoreboard queue; a negedge monitor pops and compares
// every ram_we it sees and mirrors the writes into a local RAM image.
// Build with +define+RAM_LOADER_CHECKSUM_EN to exercise the checksum variant.
`timescale 1ns/1ps
module tb_ram_loader;

  localparam int ADDR_W = 4;
  localparam int HOLD   = 2;
  localparam int DEPTH  = 2 ** ADDR_W;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'd0;
  logic              reload   = 1'b0;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              cpu_reset;
  logic              loaded;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_w;
  logic [7:0] tb_ram [DEPTH];
  logic [7:0] img    [DEPTH];
  int         checks   = 0;
  int         failures = 0;

  ram_loader #(.ADDR_W(ADDR_W), .HOLD(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 ram_addr, ram_data);
      end else begin
        mon_w = exp_q.pop_front();
        check("write_addr", 32'(ram_addr), 32'(mon_w.addr));
        check("write_data", 32'(ram_data), 32'(mon_w.data));
      end
      tb_ram[ram_addr] = ram_data;
    end
  end

  // Outputs expected in WAIT_LEN straight after a reset.
  task automatic check_reset_state();
    check("rst_ram_we",    32'(ram_we),    0);
    check("rst_ram_addr",  32'(ram_addr),  0);
    check("rst_ram_data",  32'(ram_data),  0);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_loaded",    32'(loaded),    0);
    check("rst_error",     32'(error),     0);
    check("rst_pending",   32'(exp_q.size()), 0);
  endtask

  // All driver tasks start and end just after a rising edge.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    reload   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
  endtask

  // Offer one byte after 'idle' empty cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int idle);
    bit ok = 1'b0;
    repeat (idle) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: byte %0h not accepted in 100 cycles", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Send length n, img[0..n-1] and (checksum build) the checksum byte.
  // gap >= 0: fixed idle cycles before each byte; gap < 0: random 0..2.
  task automatic send_image(input int n, input int gap, input bit corrupt);
    logic [7:0] s = 8'd0;
    send_byte(8'(n), 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: img[i]});
      s = s + img[i];
      send_byte(img[i], (gap < 0) ? $urandom_range(0, 2) : gap);
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    send_byte(corrupt ? s + 8'd1 : s, 0);
`else
    if (corrupt) s = 8'd0;
`endif
  endtask

  // After the final accepted byte: the final write (plain build) takes one
  // cycle, then HOLD cycles with cpu_reset high, then the CPU runs.
  task automatic wait_run();
    int n  = 0;
    bit up = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (cpu_reset === 1'b0) begin
        n  = k;
        up = 1'b1;
        break;
      end
    end
    if (!up) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: cpu_reset high after 200 cycles, expected low");
    end else begin
      check("release_cycle", 32'(n), 32'(HOLD + (CS_EN ? 1 : 2)));
      check("run_loaded",   32'(loaded),   1);
      check("run_in_ready", 32'(in_ready), 0);
      check("run_error",    32'(error),    0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_error();
    repeat (2) @(negedge clk);
    check("err_error",     32'(error),     1);
    check("err_in_ready",  32'(in_ready),  0);
    check("err_cpu_reset", 32'(cpu_reset), 1);
    check("err_loaded",    32'(loaded),    0);
    check("err_ram_we",    32'(ram_we),    0);
    @(posedge clk); #1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    check("reload_cpu_reset", 32'(cpu_reset), 1);
    check("reload_loaded",    32'(loaded),    0);
    check("reload_in_ready",  32'(in_ready),  1);
    @(posedge clk); #1;
  endtask

  task automatic check_ram(input int n);
    for (int i = 0; i < n; i++) begin
      check("ram_content", 32'(tb_ram[i]), 32'(img[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit in_run;
    bit corrupt;
    int n;

    do_reset();

    // Basic image 03,0A,0B,0C.
    img[0] = 8'h0A; img[1] = 8'h0B; img[2] = 8'h0C;
    send_image(3, 0, 1'b0);
    wait_run();
    check_ram(3);

    // Upstream bytes in RUN are ignored (monitor flags any write).
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("run_ignore_loaded",   32'(loaded),   1);
    check("run_ignore_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;

    // Reload then 01,76.
    do_reload();
    img[0] = 8'h76;
    send_image(1, 0, 1'b0);
    wait_run();
    check_ram(1);

    // Same 3-byte image with in_valid low every other cycle.
    do_reload();
    img[0] = 8'h0A; img[1] = 8'h0B; img[2] = 8'h0C;
    send_image(3, 1, 1'b0);
    wait_run();
    check_ram(3);

    // Full-capacity image.
    do_reload();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    send_image(DEPTH, 0, 1'b0);
    wait_run();
    check_ram(DEPTH);

    // Random images with random gaps (and bad checksums when enabled).
    in_run = 1'b1;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
      corrupt = CS_EN && ($urandom_range(0, 3) == 0);
      if (in_run) do_reload();
      send_image(n, -1, corrupt);
      if (corrupt) begin
        wait_error();
        do_reset();
        in_run = 1'b0;
      end else begin
        wait_run();
        check_ram(n);
        in_run = 1'b1;
      end
    end
    do_reset();

`ifdef RAM_LOADER_CHECKSUM_EN
    // 02,01,02 with checksum 04: both writes happen, then error.
    img[0] = 8'h01; img[1] = 8'h02;
    send_image(2, 0, 1'b1);
    wait_error();
    do_reset();
`endif

    // Length 00: error, further bytes and reload ignored.
    send_byte(8'h00, 0);
    wait_error();
    in_valid = 1'b1;
    in_data  = 8'h03;
    reload   = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_error();
    do_reset();

    // Length 0x11 exceeds the RAM: error.
    send_byte(8'h11, 0);
    wait_error();
    do_reset();

    // Reset after 2 of 5 data bytes, colliding with the third byte.
    send_byte(8'h05, 0);
    exp_q.push_back('{addr: ADDR_W'(0), data: 8'hA1});
    send_byte(8'hA1, 0);
    exp_q.push_back('{addr: ADDR_W'(1), data: 8'hA2});
    send_byte(8'hA2, 0);
    in_valid = 1'b1;
    in_data  = 8'hA3;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    img[0] = 8'hFF;
    send_image(1, 0, 1'b0);
    wait_run();
    check("reload_addr0", 32'(tb_ram[0]), 32'h00FF);
    check("untouched_addr1", 32'(tb_ram[1]), 32'h00A2);

    repeat (3) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
